// File: rtl/adder_pkg.sv
// Shared elaboration helpers for the pipelined adder: parameter legality
// and the per-stage chunk width.
package adder_pkg;

   function automatic bit params_legal(input int width, input int stages);
      return (width >= 1) && (stages >= 1) && ((width % stages) == 0);
   endfunction

   function automatic int chunk_width(input int width, input int stages);
      return (stages >= 1) ? (width / stages) : width;
   endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational W-bit ripple adder slice; also reports the carry into its
// MSB so the last slice can derive signed overflow.
module add_slice #(
   parameter int W = 8
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_ci,
   output logic [W-1:0] o_s,
   output logic         o_co,
   output logic         o_c_msb
);

   // Bit-serial ripple; o_c_msb ends up holding the carry entering bit W-1
   always_comb begin : ripple
      logic c;
      c       = i_ci;
      o_s     = '0;
      o_c_msb = 1'b0;
      for (int i = 0; i < W; i++) begin
         o_c_msb = c;
         o_s[i]  = i_a[i] ^ i_b[i] ^ c;
         c       = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
      end
      o_co = c;
   end

endmodule

// File: rtl/pipelined_adder.sv
// STAGES-deep carry-pipelined adder/subtractor with valid/ready flow control.
// Operands shift right one chunk per stage; sum chunks accumulate in place.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int CHUNK = chunk_width(WIDTH, STAGES);

   if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
      $error("pipelined_adder: need WIDTH >= 1, STAGES >= 1 and WIDTH a multiple of STAGES");
   end

   logic             w_en;
   logic [WIDTH-1:0] w_op_a   [STAGES];
   logic [WIDTH-1:0] w_op_b   [STAGES];
   logic [WIDTH-1:0] w_s_in   [STAGES];
   logic [WIDTH-1:0] w_s_next [STAGES];
   logic             w_ci     [STAGES];
   logic             w_v_in   [STAGES];
   logic [CHUNK-1:0] w_chunk  [STAGES];
   logic             w_co     [STAGES];
   logic             w_c_msb  [STAGES];

   logic [WIDTH-1:0] r_a [STAGES];
   logic [WIDTH-1:0] r_b [STAGES];
   logic [WIDTH-1:0] r_s [STAGES];
   logic             r_c [STAGES];
   logic             r_v [STAGES];
   logic             r_ovf;

   assign w_en     = ~r_v[STAGES-1] | out_ready;
   assign in_ready = w_en;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
         // Subtraction is a + ~b + 1, so the head stage folds in the inversion
         assign w_op_a[k] = a;
         assign w_op_b[k] = sub ? ~b : b;
         assign w_ci[k]   = sub ? 1'b1 : cin;
         assign w_s_in[k] = '0;
         assign w_v_in[k] = in_valid;
      end else begin : g_body
         assign w_op_a[k] = r_a[k-1];
         assign w_op_b[k] = r_b[k-1];
         assign w_ci[k]   = r_c[k-1];
         assign w_s_in[k] = r_s[k-1];
         assign w_v_in[k] = r_v[k-1];
      end

      add_slice #(.W(CHUNK)) u_slice (
         .i_a     (w_op_a[k][CHUNK-1:0]),
         .i_b     (w_op_b[k][CHUNK-1:0]),
         .i_ci    (w_ci[k]),
         .o_s     (w_chunk[k]),
         .o_co    (w_co[k]),
         .o_c_msb (w_c_msb[k])
      );

      assign w_s_next[k] = w_s_in[k] | (WIDTH'(w_chunk[k]) << (k * CHUNK));
   end

   // Stage registers: all advance together on w_en, cleared by reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_s[k] <= '0;
            r_c[k] <= 1'b0;
            r_v[k] <= 1'b0;
         end
         r_ovf <= 1'b0;
      end else if (w_en) begin
         for (int k = 0; k < STAGES; k++) begin
            r_a[k] <= w_op_a[k] >> CHUNK;
            r_b[k] <= w_op_b[k] >> CHUNK;
            r_s[k] <= w_s_next[k];
            r_c[k] <= w_co[k];
            r_v[k] <= w_v_in[k];
         end
         r_ovf <= w_c_msb[STAGES-1] ^ w_co[STAGES-1];
      end
   end

   assign out_valid = r_v[STAGES-1];
   assign s         = r_s[STAGES-1];
   assign cout      = r_c[STAGES-1];
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: three instances (STAGES 2, 1, 8 at WIDTH 8)
// checked every cycle against an arithmetic scoreboard model.
module tb_pipelined_adder;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_v [3];
   logic       in_r [3];
   logic       o_rdy [3];
   logic       o_v [3];
   logic       cin_v [3];
   logic       sub_v [3];
   logic       cout_v [3];
   logic       ovf_v [3];
   logic [7:0] a_v [3];
   logic [7:0] b_v [3];
   logic [7:0] s_v [3];

   always #5 clk = ~clk;

   pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_v[0]), .in_ready(in_r[0]),
      .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]), .sub(sub_v[0]),
      .out_valid(o_v[0]), .out_ready(o_rdy[0]), .s(s_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));

   pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_v[1]), .in_ready(in_r[1]),
      .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]), .sub(sub_v[1]),
      .out_valid(o_v[1]), .out_ready(o_rdy[1]), .s(s_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));

   pipelined_adder #(.WIDTH(8), .STAGES(8)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_v[2]), .in_ready(in_r[2]),
      .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]), .sub(sub_v[2]),
      .out_valid(o_v[2]), .out_ready(o_rdy[2]), .s(s_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));

   typedef struct packed {
      int         d;
      logic [9:0] e;    // {ovf, cout, s}
      int         acc;
      int         st;
   } exp_t;

   exp_t       q[$];
   int         n_chk = 0;
   int         n_pass = 0;
   int         cyc = 0;
   int         stalls [3] = '{0, 0, 0};
   int         delivered [3] = '{0, 0, 0};
   logic       pres [3] = '{1'b0, 1'b0, 1'b0};
   logic       hold_prev [3] = '{1'b0, 1'b0, 1'b0};
   logic [9:0] last [3] = '{10'd0, 10'd0, 10'd0};
   logic       rst_prev = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic int stg(input int d);
      return (d == 0) ? 2 : ((d == 1) ? 1 : 8);
   endfunction

   // Reference: integer arithmetic; signed overflow as a range check
   function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                        input logic c, input logic m);
      int   ua, ub, sa, sb2, u, sg;
      logic cy;
      ua  = int'(x);
      ub  = int'(y);
      sa  = int'($signed(x));
      sb2 = int'($signed(y));
      if (m) begin
         u  = ua - ub;
         sg = sa - sb2;
         cy = (ua >= ub);
      end else begin
         u  = ua + ub + int'(c);
         sg = sa + sb2 + int'(c);
         cy = (u > 255);
      end
      return {(sg > 127) || (sg < -128), cy, 8'(u)};
   endfunction

   function automatic int find_idx(input int d);
      for (int i = 0; i < q.size(); i++) if (q[i].d == d) return i;
      return -1;
   endfunction

   function automatic int count_d(input int d);
      int n = 0;
      for (int i = 0; i < q.size(); i++) if (q[i].d == d) n++;
      return n;
   endfunction

   // Compare process: checks every DUT at the negedge, then updates the scoreboard
   always @(negedge clk) begin
      cyc++;
      for (int d = 0; d < 3; d++) begin
         if (rst_prev)
            chk($sformatf("reset_state_d%0d", d), {o_v[d], cout_v[d], ovf_v[d], s_v[d]}, 32'd0);
         else if (hold_prev[d])
            chk($sformatf("hold_d%0d", d), {o_v[d], ovf_v[d], cout_v[d], s_v[d]}, {1'b1, last[d]});
         chk($sformatf("in_ready_d%0d", d), in_r[d], (!o_v[d]) || o_rdy[d]);
         if (o_v[d] === 1'b1 && !rst_prev) begin
            if (find_idx(d) < 0) begin
               chk($sformatf("spurious_out_d%0d", d), o_v[d], 32'd0);
            end else begin
               chk($sformatf("result_d%0d", d), {ovf_v[d], cout_v[d], s_v[d]}, q[find_idx(d)].e);
               if (!pres[d]) begin
                  chk($sformatf("latency_d%0d", d),
                      cyc - q[find_idx(d)].acc - (stalls[d] - q[find_idx(d)].st), stg(d));
                  pres[d] = 1'b1;
               end
            end
         end
      end
      if (rst_n !== 1'b1) begin
         q.delete();
         for (int d = 0; d < 3; d++) begin
            pres[d]      = 1'b0;
            hold_prev[d] = 1'b0;
         end
         rst_prev = 1'b1;
      end else begin
         rst_prev = 1'b0;
         for (int d = 0; d < 3; d++) begin
            if (o_v[d] === 1'b1 && o_rdy[d] && find_idx(d) >= 0) begin
               q.delete(find_idx(d));
               pres[d] = 1'b0;
               delivered[d]++;
            end
            if (o_v[d] === 1'b1 && !o_rdy[d]) stalls[d]++;
            if (in_v[d] && in_r[d] === 1'b1)
               q.push_back('{d: d, e: model(a_v[d], b_v[d], cin_v[d], sub_v[d]),
                             acc: cyc, st: stalls[d]});
            hold_prev[d] = (o_v[d] === 1'b1) && !o_rdy[d];
            last[d]      = {ovf_v[d], cout_v[d], s_v[d]};
         end
      end
   end

   task automatic directed(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                           input logic ts, input logic [7:0] es, input logic ec, input logic eo);
      @(posedge clk); #1;
      a_v[0] = ta; b_v[0] = tb; cin_v[0] = tc; sub_v[0] = ts;
      in_v[0] = 1'b1; o_rdy[0] = 1'b1;
      @(posedge clk); #1;
      in_v[0] = 1'b0;
      chk("lit_not_early", o_v[0], 32'd0);
      @(posedge clk); #1;
      chk("lit_valid", o_v[0], 32'd1);
      chk("lit_s", s_v[0], es);
      chk("lit_cout", cout_v[0], ec);
      chk("lit_ovf", ovf_v[0], eo);
   endtask

   task automatic drain(input int n);
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
         in_v[d]  = 1'b0;
         o_rdy[d] = 1'b1;
      end
      repeat (n) @(posedge clk);
   endtask

   task automatic run_random(input int d, input int n, input int budget);
      int acc = 0;
      int t = 0;
      while (acc < n && t < budget) begin
         @(posedge clk); #1;
         a_v[d]   = 8'($urandom);
         b_v[d]   = 8'($urandom);
         cin_v[d] = 1'($urandom);
         sub_v[d] = 1'($urandom);
         in_v[d]  = ($urandom_range(0, 3) != 0);
         o_rdy[d] = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (in_v[d] && in_r[d]) acc++;
         t++;
      end
      chk($sformatf("rand_accepted_d%0d", d), acc, n);
      drain(2 * stg(d) + 4);
   endtask

   task automatic stall_scenario();
      int idx = 0;
      int base = delivered[0];
      for (int t = 0; t < 12; t++) begin
         @(posedge clk); #1;
         o_rdy[0] = !(t >= 3 && t <= 6);
         in_v[0]  = (idx < 5);
         a_v[0]   = 8'(idx * 37 + 200);
         b_v[0]   = 8'(idx * 91);
         cin_v[0] = idx[0];
         sub_v[0] = (idx == 2);
         @(negedge clk);
         if (t == 4) chk("stall_in_ready", in_r[0], 32'd0);
         if (in_v[0] && in_r[0]) idx++;
      end
      chk("stall_accepted", idx, 32'd5);
      drain(6);
      chk("stall_delivered", delivered[0] - base, 32'd5);
   endtask

   task automatic midflight_reset();
      int seen = 0;
      @(posedge clk); #1;
      a_v[2] = 8'h12; b_v[2] = 8'h34; cin_v[2] = 1'b0; sub_v[2] = 1'b0;
      in_v[2] = 1'b1; o_rdy[2] = 1'b1;
      @(posedge clk); #1;
      a_v[2] = 8'hF0; b_v[2] = 8'h0F; sub_v[2] = 1'b1;
      @(posedge clk); #1;
      in_v[2] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rst_mid_out_valid", o_v[2], 32'd0);
      chk("rst_mid_s", s_v[2], 32'd0);
      for (int t = 0; t < 14; t++) begin
         @(negedge clk);
         if (o_v[2]) seen++;
      end
      chk("rst_mid_no_result", seen, 32'd0);
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         in_v[d] = 1'b0; o_rdy[d] = 1'b1; cin_v[d] = 1'b0; sub_v[d] = 1'b0;
         a_v[d] = 8'h00; b_v[d] = 8'h00;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", in_r[0], 32'd1);
      chk("reset_out_valid", o_v[0], 32'd0);
      rst_n = 1'b1;

      directed(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
      directed(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
      directed(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      directed(8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
      directed(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
      drain(4);

      stall_scenario();
      midflight_reset();
      drain(4);

      run_random(0, 300, 3000);
      run_random(1, 1000, 10000);
      run_random(2, 1000, 10000);
      drain(30);

      for (int d = 0; d < 3; d++) chk($sformatf("drained_d%0d", d), count_d(d), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
